lib_voq_input_buffer: RTL

Per-input virtual output queue (VOQ) buffer that sits directly upstream of the NxM separable round-robin allocator. It holds M independent FIFOs, one per output, and drives this input's M-bit request row to the allocator. It consumes this input's one-hot grant and delivers the granted head-of-line word, registered, to the crossbar stage. Removing head-of-line blocking is the reason the block exists: a stalled output never blocks traffic queued for other outputs.

---
 rtl/lib_voq_input_buffer_if.sv | 40 ++++
 rtl/lib_voq_input_buffer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lib_voq_input_buffer_if.sv
// ---------------------------------------------------------------------------
// lib_voq_input_buffer_if
//
// Bundles the signals between one input's VOQ buffer, its upstream word
// source, and the allocator and crossbar.
//   i_data/i_dest/i_valid : incoming word, its destination output, and a strobe
//   o_ready               : the addressed VOQ has room (combinational)
//   o_request [0:M-1]     : request row to the allocator (bit k = VOQ k non-empty)
//   i_grant   [0:M-1]     : this input's grant row from the allocator
//   o_valid/o_data/o_dest : registered popped word and the VOQ it came from
//   o_error               : registered one-cycle pulse on an illegal grant
// Modports: master = source/allocator side, slave = the buffer.
// ---------------------------------------------------------------------------
interface lib_voq_input_buffer_if #(
  parameter int M     = 4,
  parameter int WIDTH = 32
) ();
  localparam int DW = $clog2(M);

  logic [WIDTH-1:0] i_data;
  logic [DW-1:0]    i_dest;
  logic             i_valid;
  logic             o_ready;
  logic [0:M-1]     o_request;
  logic [0:M-1]     i_grant;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [DW-1:0]    o_dest;
  logic             o_error;

  modport master (
    output i_data, i_dest, i_valid, i_grant,
    input  o_ready, o_request, o_valid, o_data, o_dest, o_error
  );

  modport slave (
    input  i_data, i_dest, i_valid, i_grant,
    output o_ready, o_request, o_valid, o_data, o_dest, o_error
  );
endinterface

// File: rtl/lib_voq_input_buffer.sv
// ---------------------------------------------------------------------------
// lib_voq_input_buffer
//
// Per-input virtual output queue buffer. Holds M independent FIFOs (one per
// output) of DEPTH words each, so a stalled output never blocks words queued
// for the other outputs. Drives the allocator request row and pops the
// granted head-of-line word into a register for the crossbar.
//
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears pointers, counts and outputs
//   bus   : lib_voq_input_buffer_if.slave (see interface header)
// ---------------------------------------------------------------------------
module lib_voq_input_buffer #(
  parameter int M     = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  lib_voq_input_buffer_if.slave  bus
);
  localparam int DW = $clog2(M);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Shared storage; VOQ k occupies entries {k, ptr}.
  logic [WIDTH-1:0] mem [M*DEPTH];

  logic [PW-1:0]    wr_ptr_reg [M];
  logic [PW-1:0]    rd_ptr_reg [M];
  logic [CW-1:0]    count_reg  [M];
  logic [CW-1:0]    count_next [M];
  logic [0:M-1]     request_reg;

  logic [M-1:0]     push_vec;
  logic [M-1:0]     pop_vec;
  logic [0:M-1]     grant_hit;
  logic             ready;
  logic             push;
  logic             pop_any;
  logic [DW-1:0]    pop_idx;
  logic             error_next;

  logic             valid_reg;
  logic             error_reg;
  logic [WIDTH-1:0] data_reg;
  logic [DW-1:0]    dest_reg;

  // Room is judged on the current count only; a same-cycle pop does not
  // free a slot early.
  assign ready = (count_reg[bus.i_dest] != CW'(DEPTH));
  assign push  = bus.i_valid && ready;

  // Honour the lowest-index granted bit that actually has a request.
  // Grants on empty VOQs and multi-bit grants are flagged as errors.
  always_comb begin
    grant_hit  = bus.i_grant & request_reg;
    pop_any    = 1'b0;
    pop_idx    = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (grant_hit[k]) begin
        pop_any = 1'b1;
        pop_idx = DW'(k);
      end
    end
    error_next = ($countones(bus.i_grant) > 1) || (|(bus.i_grant & ~request_reg));
  end

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_voq
      assign push_vec[gi]   = push && (bus.i_dest == DW'(gi));
      assign pop_vec[gi]    = pop_any && (pop_idx == DW'(gi));
      // Simultaneous push and pop leaves the count unchanged.
      assign count_next[gi] = count_reg[gi] + CW'(push_vec[gi]) - CW'(pop_vec[gi]);
    end
  endgenerate

  // Per-VOQ pointer/count state. Pointers wrap naturally as DEPTH is a
  // power of two. Request is derived from the next count so it never lags
  // a pop of the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < M; k++) begin
        wr_ptr_reg[k] <= '0;
        rd_ptr_reg[k] <= '0;
        count_reg[k]  <= '0;
      end
      request_reg <= '0;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (push_vec[k]) wr_ptr_reg[k] <= wr_ptr_reg[k] + PW'(1);
        if (pop_vec[k])  rd_ptr_reg[k] <= rd_ptr_reg[k] + PW'(1);
        count_reg[k]   <= count_next[k];
        request_reg[k] <= (count_next[k] != '0);
      end
    end
  end

  // Storage write port; contents survive reset, but no write happens in
  // the reset cycle.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[{bus.i_dest, wr_ptr_reg[bus.i_dest]}] <= bus.i_data;
    end
  end

  // Registered read of the granted head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      data_reg  <= '0;
      dest_reg  <= '0;
    end else begin
      valid_reg <= pop_any;
      error_reg <= error_next;
      if (pop_any) begin
        data_reg <= mem[{pop_idx, rd_ptr_reg[pop_idx]}];
        dest_reg <= pop_idx;
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_request = request_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_data    = data_reg;
  assign bus.o_dest    = dest_reg;
  assign bus.o_error   = error_reg;
endmodule
